// File: rtl/ofs_plat_avalon_mem_burst_splitter_if.sv
// Avalon-MM bus bundle used on both sides of the burst splitter.
interface ofs_plat_avalon_mem_burst_splitter_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned BURST_WIDTH = 7
);
    logic                      read;
    logic                      write;
    logic [ADDR_WIDTH-1:0]     address;
    logic [BURST_WIDTH-1:0]    burstcount;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic                      waitrequest;
    logic                      readdatavalid;
    logic [DATA_WIDTH-1:0]     readdata;
    logic                      writeresponsevalid;
    logic [1:0]                response;

    modport master (
        output read, write, address, burstcount, writedata, byteenable,
        input  waitrequest, readdatavalid, readdata, writeresponsevalid, response
    );

    modport slave (
        input  read, write, address, burstcount, writedata, byteenable,
        output waitrequest, readdatavalid, readdata, writeresponsevalid, response
    );
endinterface

// File: rtl/ofs_plat_avalon_mem_burst_splitter.sv
// Splits long Avalon-MM source bursts into short sink bursts, honouring page
// boundaries and natural alignment, and merges the per-sink write responses.
module ofs_plat_avalon_mem_burst_splitter #(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned DATA_WIDTH        = 512,
    parameter int unsigned SRC_BURST_WIDTH   = 7,
    parameter int unsigned SNK_BURST_WIDTH   = 3,
    parameter int unsigned NATURAL_ALIGNMENT = 0,
    parameter int unsigned PAGE_LINES        = 0,
    parameter int unsigned WR_TRACK_DEPTH    = 32
) (
    input  logic clk,
    input  logic reset_n,
    ofs_plat_avalon_mem_burst_splitter_if.slave  src,
    ofs_plat_avalon_mem_burst_splitter_if.master snk
);

    localparam int unsigned MAXB  = 32'(1) << (SNK_BURST_WIDTH - 1);
    localparam int unsigned PTR_W = (WR_TRACK_DEPTH > 1) ? $clog2(WR_TRACK_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WR_TRACK_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_DATA} state_t;

    // Length of the next sink burst starting at addr with rem beats left.
    function automatic logic [31:0] burst_len(input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [31:0] rem);
        logic [31:0] a;
        logic [31:0] lim;
        logic [31:0] room;
        logic [31:0] res;
        a   = 32'(addr);
        lim = (rem < MAXB) ? rem : MAXB;
        if (PAGE_LINES != 0) begin
            room = PAGE_LINES - (a & (PAGE_LINES - 1));
            if (room < lim) lim = room;
        end
        res = lim;
        if (NATURAL_ALIGNMENT != 0) begin
            res = 32'd1;
            for (int unsigned i = 0; i < SNK_BURST_WIDTH; i++) begin
                if (((32'(1) << i) <= lim) && ((a & ((32'(1) << i) - 32'd1)) == 32'd0))
                    res = 32'(1) << i;
            end
        end
        return res;
    endfunction

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [SRC_BURST_WIDTH-1:0]   rem_q, rem_d;
    logic [SNK_BURST_WIDTH-1:0]   beats_q, beats_d;

    logic                         rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]        oaddr_q, oaddr_d;
    logic [SNK_BURST_WIDTH-1:0]   obc_q, obc_d;
    logic [DATA_WIDTH-1:0]        odata_q, odata_d;
    logic [DATA_WIDTH/8-1:0]      obe_q, obe_d;

    logic                         fifo_mem [WR_TRACK_DEPTH];
    logic [PTR_W-1:0]             wptr_q, rptr_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [1:0]                   err_q;

    logic                         adv, fifo_full, wr_sop_pend, src_wait_c;
    logic                         push, push_bit, pop, head;
    logic [ADDR_WIDTH-1:0]        cur_addr;
    logic [31:0]                  cur_rem, len;

    // Shared burst-length computation for whichever command is being formed.
    always_comb begin
        adv         = !snk.waitrequest;
        fifo_full   = (cnt_q == CNT_W'(WR_TRACK_DEPTH));
        wr_sop_pend = ((state_q == IDLE) && src.write) ||
                      ((state_q == WR_DATA) && (beats_q == '0));
        src_wait_c  = snk.waitrequest || (state_q == RD_SPLIT) || (wr_sop_pend && fifo_full);
        cur_addr    = (state_q == IDLE) ? src.address : addr_q;
        cur_rem     = (state_q == IDLE) ? 32'(src.burstcount) : 32'(rem_q);
        len         = burst_len(cur_addr, cur_rem);
        pop         = snk.writeresponsevalid && (cnt_q != '0);
        head        = fifo_mem[rptr_q];
    end

    // Next-state and sink output register contents.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        beats_d  = beats_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        oaddr_d  = oaddr_q;
        obc_d    = obc_q;
        odata_d  = odata_q;
        obe_d    = obe_q;
        push     = 1'b0;
        push_bit = 1'b0;

        if (adv) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (src.read && !src_wait_c) begin
                    rd_d    = 1'b1;
                    oaddr_d = src.address;
                    obc_d   = SNK_BURST_WIDTH'(len);
                    addr_d  = src.address + ADDR_WIDTH'(len);
                    rem_d   = src.burstcount - SRC_BURST_WIDTH'(len);
                    if (rem_d != '0) state_d = RD_SPLIT;
                end else if (src.write && !src_wait_c) begin
                    wr_d     = 1'b1;
                    odata_d  = src.writedata;
                    obe_d    = src.byteenable;
                    oaddr_d  = src.address;
                    obc_d    = SNK_BURST_WIDTH'(len);
                    push     = 1'b1;
                    push_bit = (len == cur_rem);
                    beats_d  = SNK_BURST_WIDTH'(len - 32'd1);
                    addr_d   = src.address + ADDR_WIDTH'(len);
                    rem_d    = src.burstcount - SRC_BURST_WIDTH'(1);
                    if (src.burstcount != SRC_BURST_WIDTH'(1)) state_d = WR_DATA;
                end
            end
            RD_SPLIT: begin
                if (adv) begin
                    rd_d    = 1'b1;
                    oaddr_d = addr_q;
                    obc_d   = SNK_BURST_WIDTH'(len);
                    addr_d  = addr_q + ADDR_WIDTH'(len);
                    rem_d   = rem_q - SRC_BURST_WIDTH'(len);
                    if (rem_d == '0) state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (src.write && !src_wait_c) begin
                    wr_d    = 1'b1;
                    odata_d = src.writedata;
                    obe_d   = src.byteenable;
                    rem_d   = rem_q - SRC_BURST_WIDTH'(1);
                    if (beats_q == '0) begin
                        oaddr_d  = addr_q;
                        obc_d    = SNK_BURST_WIDTH'(len);
                        push     = 1'b1;
                        push_bit = (len == cur_rem);
                        beats_d  = SNK_BURST_WIDTH'(len - 32'd1);
                        addr_d   = addr_q + ADDR_WIDTH'(len);
                    end else begin
                        beats_d = beats_q - SNK_BURST_WIDTH'(1);
                    end
                    if (rem_q == SRC_BURST_WIDTH'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            beats_q <= beats_d;
        end
    end

    // Datapath registers need no reset; they are qualified by rd_q/wr_q/state.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        rem_q   <= rem_d;
        oaddr_q <= oaddr_d;
        obc_q   <= obc_d;
        odata_q <= odata_d;
        obe_q   <= obe_d;
    end

    // Tracking FIFO: one bit per sink write burst, set on a source-EOP burst.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q] <= push_bit;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 2'b00;
        end else begin
            if (push) wptr_q <= (wptr_q == PTR_W'(WR_TRACK_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= (rptr_q == PTR_W'(WR_TRACK_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (pop) begin
                if (head)                 err_q <= 2'b00;
                else if (err_q == 2'b00)  err_q <= snk.response;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if ((state_q == IDLE) && (src.read || src.write) && !src_wait_c)
                assert (src.burstcount != '0) else $fatal(1, "source burstcount of zero");
            if (snk.writeresponsevalid)
                assert (cnt_q != '0) else $fatal(1, "write response with no burst outstanding");
        end
    end

    assign src.waitrequest        = src_wait_c;
    assign src.readdatavalid      = snk.readdatavalid;
    assign src.readdata           = snk.readdata;
    assign src.writeresponsevalid = reset_n && pop && head;
    assign src.response           = (snk.writeresponsevalid && (err_q != 2'b00)) ? err_q : snk.response;

    assign snk.read       = rd_q;
    assign snk.write      = wr_q;
    assign snk.address    = oaddr_q;
    assign snk.burstcount = obc_q;
    assign snk.writedata  = odata_q;
    assign snk.byteenable = obe_q;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_burst_splitter.sv
// Directed scoreboard bench for the Avalon-MM burst splitter.
module tb_ofs_plat_avalon_mem_burst_splitter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned SBW = 7;
    localparam int unsigned KBW = 3;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } cmd_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ofs_plat_avalon_mem_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(SBW)) src_if ();
    ofs_plat_avalon_mem_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(KBW)) snk_if ();

    ofs_plat_avalon_mem_burst_splitter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_BURST_WIDTH(SBW), .SNK_BURST_WIDTH(KBW),
        .NATURAL_ALIGNMENT(1), .PAGE_LINES(64), .WR_TRACK_DEPTH(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .src(src_if), .snk(snk_if)
    );

    cmd_t        exp_rd_q[$];
    cmd_t        exp_wb_q[$];
    logic [63:0] exp_wdata_q[$];
    logic [63:0] exp_rdata_q[$];
    logic [1:0]  exp_rresp_q[$];
    logic [1:0]  exp_resp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int wr_beats_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected/arrived", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one source command/beat and hold it until accepted.
    task automatic src_beat(input bit rd, input bit wr, input logic [31:0] a,
                            input int bc, input logic [63:0] d);
        int n;
        src_if.read       = rd;
        src_if.write      = wr;
        src_if.address    = a;
        src_if.burstcount = SBW'(bc);
        src_if.writedata  = d;
        src_if.byteenable = d[7:0];
        n = 0;
        forever begin
            @(negedge clk);
            if (!src_if.waitrequest) break;
            n++;
            if (n > 300) begin
                fail_now("src_accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        src_if.read  = 1'b0;
        src_if.write = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] a, input int bc);
        for (int i = 0; i < bc; i++) begin
            logic [63:0] d;
            d = {a, 32'(i) ^ 32'h5A00_0000};
            exp_wdata_q.push_back(d);
            src_beat(1'b0, 1'b1, a, bc, d);
        end
    endtask

    task automatic rd_return(input logic [63:0] d, input logic [1:0] r);
        exp_rdata_q.push_back(d);
        exp_rresp_q.push_back(r);
        snk_if.readdatavalid = 1'b1;
        snk_if.readdata      = d;
        snk_if.response      = r;
        tick();
        snk_if.readdatavalid = 1'b0;
        snk_if.response      = 2'b00;
    endtask

    task automatic wr_resp(input logic [1:0] r, input bit fwd, input logic [1:0] e);
        if (fwd) exp_resp_q.push_back(e);
        snk_if.writeresponsevalid = 1'b1;
        snk_if.response           = r;
        tick();
        snk_if.writeresponsevalid = 1'b0;
        snk_if.response           = 2'b00;
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    initial begin
        cmd_t c;
        int   mon_left;
        mon_left = 0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (snk_if.read && !snk_if.waitrequest) begin
                    if (exp_rd_q.size() == 0) fail_now("unexpected_snk_read");
                    else begin
                        c = exp_rd_q.pop_front();
                        check("snk_rd_addr", 64'(snk_if.address), 64'(c.addr));
                        check("snk_rd_len", 64'(snk_if.burstcount), 64'(c.len));
                    end
                end
                if (snk_if.write && !snk_if.waitrequest) begin
                    wr_beats_seen++;
                    if (mon_left == 0) begin
                        if (exp_wb_q.size() == 0) fail_now("unexpected_snk_wr_burst");
                        else begin
                            c = exp_wb_q.pop_front();
                            check("snk_wr_addr", 64'(snk_if.address), 64'(c.addr));
                            check("snk_wr_len", 64'(snk_if.burstcount), 64'(c.len));
                            mon_left = c.len;
                        end
                    end
                    if (mon_left > 0) mon_left--;
                    if (exp_wdata_q.size() == 0) fail_now("unexpected_snk_wr_beat");
                    else begin
                        logic [63:0] d;
                        d = exp_wdata_q.pop_front();
                        check("snk_wr_data", snk_if.writedata, d);
                        check("snk_wr_be", 64'(snk_if.byteenable), 64'(d[7:0]));
                    end
                end
                if (src_if.readdatavalid) begin
                    if (exp_rdata_q.size() == 0) fail_now("unexpected_src_readdatavalid");
                    else begin
                        check("src_readdata", src_if.readdata, exp_rdata_q.pop_front());
                        check("src_rd_response", 64'(src_if.response), 64'(exp_rresp_q.pop_front()));
                    end
                end
                if (src_if.writeresponsevalid) begin
                    if (exp_resp_q.size() == 0) fail_now("unexpected_src_writeresponse");
                    else check("src_wr_response", 64'(src_if.response), 64'(exp_resp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int exp_beats [6] = '{8, 12, 16, 20, 24, 24};
        logic [1:0] rsp [6] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
        bit         fwd [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] ersp[6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

        reset_n = 1'b0;
        src_if.read = 1'b0; src_if.write = 1'b0; src_if.address = '0; src_if.burstcount = '0;
        src_if.writedata = '0; src_if.byteenable = '0;
        snk_if.waitrequest = 1'b0; snk_if.readdatavalid = 1'b0; snk_if.readdata = '0;
        snk_if.writeresponsevalid = 1'b0; snk_if.response = 2'b00;
        repeat (3) tick();
        @(negedge clk);
        check("reset_snk_read", 64'(snk_if.read), 64'd0);
        check("reset_snk_write", 64'(snk_if.write), 64'd0);
        check("reset_src_wrrespvalid", 64'(src_if.writeresponsevalid), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Aligned read 0x10 x8 -> two bursts of 4, one extra stall cycle.
        exp_rd_q.push_back('{32'h10, 4});
        exp_rd_q.push_back('{32'h14, 4});
        src_beat(1'b1, 1'b0, 32'h10, 8, 64'd0);
        @(negedge clk);
        check("rd_split_waitreq", 64'(src_if.waitrequest), 64'd1);
        tick();
        @(negedge clk);
        check("rd_idle_waitreq", 64'(src_if.waitrequest), 64'd0);
        tick();

        // Unaligned read 0x11 x5 -> 1,2,2 and five beats passed through.
        exp_rd_q.push_back('{32'h11, 1});
        exp_rd_q.push_back('{32'h12, 2});
        exp_rd_q.push_back('{32'h14, 2});
        src_beat(1'b1, 1'b0, 32'h11, 5, 64'd0);
        repeat (4) tick();
        for (int i = 0; i < 5; i++)
            rd_return(64'hA5A5_0000_0000_0000 | 64'(i * 17), (i == 2) ? 2'b10 : 2'b00);
        tick();

        // Page-crossing write 0x3E x4, SLVERR then OKAY merges to SLVERR.
        exp_wb_q.push_back('{32'h3E, 2});
        exp_wb_q.push_back('{32'h40, 2});
        wr_burst(32'h3E, 4);
        repeat (3) tick();
        wr_resp(2'b10, 1'b0, 2'b00);
        wr_resp(2'b00, 1'b1, 2'b10);
        repeat (2) tick();

        // Three writes of 8 against a depth-2 tracker, responses trickled in.
        exp_wb_q.push_back('{32'h100, 4});
        exp_wb_q.push_back('{32'h104, 4});
        exp_wb_q.push_back('{32'h200, 4});
        exp_wb_q.push_back('{32'h204, 4});
        exp_wb_q.push_back('{32'h300, 4});
        exp_wb_q.push_back('{32'h304, 4});
        base = wr_beats_seen;
        fork
            begin
                wr_burst(32'h100, 8);
                wr_burst(32'h200, 8);
                wr_burst(32'h300, 8);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    repeat (15) tick();
                    @(negedge clk);
                    check("stall_beats", 64'(wr_beats_seen - base), 64'(exp_beats[k]));
                    if (k == 0) check("stall_waitreq", 64'(src_if.waitrequest), 64'd1);
                    tick();
                    wr_resp(rsp[k], fwd[k], ersp[k]);
                end
            end
        join
        repeat (2) tick();

        // Reset in the middle of a split read abandons it.
        src_beat(1'b1, 1'b0, 32'h0, 16, 64'd0);
        snk_if.waitrequest = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        @(negedge clk);
        check("midreset_snk_read", 64'(snk_if.read), 64'd0);
        check("midreset_snk_write", 64'(snk_if.write), 64'd0);
        tick();
        reset_n = 1'b1;
        snk_if.waitrequest = 1'b0;
        @(negedge clk);
        check("postreset_idle_waitreq", 64'(src_if.waitrequest), 64'd0);
        tick();
        exp_rd_q.push_back('{32'h0, 1});
        src_beat(1'b1, 1'b0, 32'h0, 1, 64'd0);
        repeat (3) tick();
        @(negedge clk);
        check("single_read_waitreq", 64'(src_if.waitrequest), 64'd0);

        repeat (5) tick();
        check("rd_cmd_q_drained", 64'(exp_rd_q.size()), 64'd0);
        check("wr_burst_q_drained", 64'(exp_wb_q.size()), 64'd0);
        check("wr_data_q_drained", 64'(exp_wdata_q.size()), 64'd0);
        check("rd_data_q_drained", 64'(exp_rdata_q.size()), 64'd0);
        check("wr_resp_q_drained", 64'(exp_resp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
